// File: rtl/dmem_responder.sv
// Data-memory responder: turns cache refill/store requests into word-bus beats.
// Refills assemble LINE_WORDS read beats into a registered line buffer.
module dmem_responder #(
    parameter int unsigned WORD       = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         memory_valid,
    input  logic                         memory_for_store,
    input  logic [WORD-1:0]              load_store_addr,
    input  logic [WORD-1:0]              data_to_mem,
    output logic                         memory_ready,
    output logic [WORD*LINE_WORDS-1:0]   data_from_mem,
    output logic                         ram_req,
    output logic                         ram_we,
    output logic [WORD-1:0]              ram_addr,
    output logic [WORD-1:0]              ram_wdata,
    input  logic                         ram_ack,
    input  logic [WORD-1:0]              ram_rdata
);

    localparam int unsigned BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned OFF    = BEAT_W + 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t                             state_q, state_d;
    logic [BEAT_W-1:0]                  beat_q, beat_d;
    logic [WORD-1:0]                    addr_q, addr_d;
    logic [WORD-1:0]                    wdata_q, wdata_d;
    logic                               store_q, store_d;
    logic [LINE_WORDS-1:0][WORD-1:0]    line_q, line_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            store_q <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            store_q <= store_d;
            line_q  <= line_d;
        end
    end

    // Bus outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        store_d      = store_q;
        line_d       = line_q;
        memory_ready = 1'b0;
        ram_req      = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;

        case (state_q)
            IDLE: begin
                if (memory_valid) begin
                    addr_d  = load_store_addr;
                    wdata_d = data_to_mem;
                    store_d = memory_for_store;
                    state_d = memory_for_store ? WRITE : READ;
                end
            end
            READ: begin
                ram_req  = 1'b1;
                ram_we   = store_q;
                ram_addr = {addr_q[WORD-1:OFF], beat_q, 2'b00};
                if (ram_ack) begin
                    line_d[beat_q] = ram_rdata;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                ram_req   = 1'b1;
                ram_we    = store_q;
                ram_addr  = addr_q & ~WORD'(3);
                ram_wdata = wdata_q;
                if (ram_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                memory_ready = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_from_mem = line_q;

endmodule
